vend_sequencer: RTL

//   Controller for the vending machine's shared dispense path. Takes a buy request for one of

---
 rtl/vend_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - dispense-path sequencer: stock/credit check, debit handshake, motor drive, status
module vend_sequencer #(
  parameter logic [7:0]         PRICE0      = 8'd25,
  parameter logic [7:0]         PRICE1      = 8'd50,
  parameter logic [7:0]         PRICE2      = 8'd75,
  parameter logic [7:0]         PRICE3      = 8'd100,
  parameter int                 STOCK_W     = 4,
  parameter logic [STOCK_W-1:0] STOCK_INIT  = 4'd3,
  parameter int                 TIMEOUT_CYC = 50
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_vend_req,
  input  logic [1:0]         i_vend_product,
  output logic               o_vend_ack,
  input  logic [7:0]         i_credit,
  output logic               o_debit_valid,
  output logic [7:0]         o_debit_amount,
  input  logic               i_debit_ack,
  output logic               o_refund_valid,
  output logic [7:0]         o_refund_amount,
  output logic [3:0]         o_motor_en,
  input  logic               i_motor_done,
  input  logic               i_restock_valid,
  input  logic [1:0]         i_restock_slot,
  input  logic [STOCK_W-1:0] i_restock_count,
  output logic               o_vend_done,
  output logic               o_err_valid,
  output logic [1:0]         o_err_code,
  output logic               o_busy
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DEBIT,
    S_MOTOR,
    S_REPORT
  } state_t;

  state_t             r_state;
  logic [1:0]         r_slot;
  logic [TW-1:0]      r_timer;
  logic [STOCK_W-1:0] r_stock [4];
  logic [7:0]         w_price;

  always_comb begin
    w_price = PRICE0;
    case (r_slot)
      2'd0: w_price = PRICE0;
      2'd1: w_price = PRICE1;
      2'd2: w_price = PRICE2;
      2'd3: w_price = PRICE3;
      default: w_price = PRICE0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_slot          <= 2'd0;
      r_timer         <= '0;
      for (int i = 0; i < 4; i++) r_stock[i] <= STOCK_INIT;
      o_vend_ack      <= 1'b0;
      o_debit_valid   <= 1'b0;
      o_debit_amount  <= 8'd0;
      o_refund_valid  <= 1'b0;
      o_refund_amount <= 8'd0;
      o_motor_en      <= 4'd0;
      o_vend_done     <= 1'b0;
      o_err_valid     <= 1'b0;
      o_err_code      <= 2'd0;
      o_busy          <= 1'b0;
    end else begin
      o_vend_ack      <= 1'b0;
      o_refund_valid  <= 1'b0;
      o_refund_amount <= 8'd0;
      o_vend_done     <= 1'b0;
      o_err_valid     <= 1'b0;
      o_err_code      <= 2'd0;
      case (r_state)
        S_IDLE: begin
          // A restock owns the cycle; a waiting request is picked up on the next one.
          if (i_restock_valid) begin
            r_stock[i_restock_slot] <= i_restock_count;
          end else if (i_vend_req) begin
            o_vend_ack <= 1'b1;
            r_slot     <= i_vend_product;
            o_busy     <= 1'b1;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_stock[r_slot] == '0) begin
            o_err_valid <= 1'b1;
            o_err_code  <= 2'b01;
            r_state     <= S_REPORT;
          end else if (i_credit < w_price) begin
            o_err_valid <= 1'b1;
            o_err_code  <= 2'b10;
            r_state     <= S_REPORT;
          end else begin
            r_state <= S_DEBIT;
          end
        end
        S_DEBIT: begin
          // Request is raised on the first DEBIT cycle, so the handshake completes no earlier than the second.
          if (o_debit_valid && i_debit_ack) begin
            o_debit_valid  <= 1'b0;
            o_debit_amount <= 8'd0;
            o_motor_en     <= 4'b0001 << r_slot;
            r_timer        <= '0;
            r_state        <= S_MOTOR;
          end else begin
            o_debit_valid  <= 1'b1;
            o_debit_amount <= w_price;
          end
        end
        S_MOTOR: begin
          if (i_motor_done) begin
            if (r_stock[r_slot] != '0) r_stock[r_slot] <= r_stock[r_slot] - STOCK_W'(1);
            o_motor_en  <= 4'd0;
            o_vend_done <= 1'b1;
            o_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_timer == TIMER_LAST) begin
            o_motor_en      <= 4'd0;
            o_err_valid     <= 1'b1;
            o_err_code      <= 2'b11;
            o_refund_valid  <= 1'b1;
            o_refund_amount <= w_price;
            r_state         <= S_REPORT;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_REPORT: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
